// File: rtl/mult_arb_ctrl.sv
// Two-requester round-robin front end for a shared combinational 4x4 array multiplier.
// Optional product accumulator enabled by defining MULT_ARB_ACC_EN.
module mult_arb_ctrl #(
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic       b_valid,
  output logic       a_ready,
  output logic       b_ready,
  input  logic [3:0] a_m,
  input  logic [3:0] a_q,
  input  logic [3:0] b_m,
  input  logic [3:0] b_q,
  output logic [3:0] mult_m,
  output logic [3:0] mult_q,
  input  logic [7:0] mult_p,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id
`ifdef MULT_ARB_ACC_EN
  ,
  input  logic        acc_clr,
  output logic [11:0] acc_out
`endif
);

  typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_t;

  localparam logic [3:0] LAST = 4'(SETTLE_CYC - 1);

  state_t     state, state_nxt;
  logic       ptr_b;          // 1: B wins a tie on the next contention
  logic [3:0] cnt;
  logic [3:0] op_m, op_q;
  logic       grant_a, grant_b;
  logic       accept, capture;

  assign grant_a = a_valid & (~b_valid | ~ptr_b);
  assign grant_b = b_valid & (~a_valid |  ptr_b);

  assign mult_m = op_m;
  assign mult_q = op_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        a_ready = grant_a & ~rst;
        b_ready = grant_b & ~rst;
        if (grant_a | grant_b) begin
          accept    = 1'b1;
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        if (cnt == LAST) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_b    <= 1'b0;
      cnt      <= '0;
      op_m     <= '0;
      op_q     <= '0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
    end else begin
      if (accept) begin
        op_m   <= grant_b ? b_m : a_m;
        op_q   <= grant_b ? b_q : a_q;
        rsp_id <= grant_b;
        ptr_b  <= grant_a;   // point at whoever lost
        cnt    <= '0;
      end else if (state == COMPUTE) begin
        cnt <= cnt + 4'd1;
      end
      if (capture) rsp_data <= mult_p;
    end
  end

`ifdef MULT_ARB_ACC_EN
  // A clear coinciding with a capture starts the new sum from this product.
  always_ff @(posedge clk) begin
    if (rst)                    acc_out <= '0;
    else if (acc_clr & capture) acc_out <= {4'b0, mult_p};
    else if (acc_clr)           acc_out <= '0;
    else if (capture)           acc_out <= acc_out + {4'b0, mult_p};
  end
`endif

endmodule

// File: tb/tb_mult_arb_ctrl.sv
// Self-checking bench: instance 0 runs SETTLE_CYC=1, instance 1 runs SETTLE_CYC=4.
// Accumulator checks compile in only when MULT_ARB_ACC_EN is defined.
module tb_mult_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst       [2];
  logic       a_valid   [2];
  logic       b_valid   [2];
  logic       a_ready   [2];
  logic       b_ready   [2];
  logic [3:0] a_m       [2];
  logic [3:0] a_q       [2];
  logic [3:0] b_m       [2];
  logic [3:0] b_q       [2];
  logic [3:0] mult_m    [2];
  logic [3:0] mult_q    [2];
  logic [7:0] mult_p    [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_data  [2];
  logic       rsp_id    [2];
`ifdef MULT_ARB_ACC_EN
  logic        acc_clr  [2];
  logic [11:0] acc_out  [2];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mult_arb_ctrl #(.SETTLE_CYC(g == 0 ? 1 : 4)) u_dut (
      .clk(clk), .rst(rst[g]),
      .a_valid(a_valid[g]), .b_valid(b_valid[g]),
      .a_ready(a_ready[g]), .b_ready(b_ready[g]),
      .a_m(a_m[g]), .a_q(a_q[g]), .b_m(b_m[g]), .b_q(b_q[g]),
      .mult_m(mult_m[g]), .mult_q(mult_q[g]), .mult_p(mult_p[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_data(rsp_data[g]), .rsp_id(rsp_id[g])
`ifdef MULT_ARB_ACC_EN
      , .acc_clr(acc_clr[g]), .acc_out(acc_out[g])
`endif
    );
    // behavioural array multiplier
    assign mult_p[g] = {4'b0, mult_m[g]} * {4'b0, mult_q[g]};
  end

  function automatic int settle(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic clear_inputs(input int k);
    a_valid[k] = 0; b_valid[k] = 0; rsp_ready[k] = 0;
    a_m[k] = 0; a_q[k] = 0; b_m[k] = 0; b_q[k] = 0;
`ifdef MULT_ARB_ACC_EN
    acc_clr[k] = 0;
`endif
  endtask

  task automatic do_reset(input int k);
    @(negedge clk);
    rst[k] = 1;
    clear_inputs(k);
    @(negedge clk);
    rst[k] = 0;
  endtask

  // Drives one operand pair and returns the response; ok=0 if any wait timed out.
  task automatic run_txn(input int k, input bit sel_b, input logic [3:0] m, input logic [3:0] q,
                         output logic [7:0] d, output logic id, output bit ok);
    bit hs = 0;
    ok = 0; d = '0; id = 0;
    @(negedge clk);
    if (sel_b) begin b_valid[k] = 1; b_m[k] = m; b_q[k] = q; end
    else       begin a_valid[k] = 1; a_m[k] = m; a_q[k] = q; end
    rsp_ready[k] = 1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (a_ready[k] | b_ready[k]) begin hs = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    a_valid[k] = 0; b_valid[k] = 0;
    for (int i = 0; i < 50 && hs; i++) begin
      #1;
      if (rsp_valid[k]) begin d = rsp_data[k]; id = rsp_id[k]; ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    rsp_ready[k] = 0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst[k] = 1;
      clear_inputs(k);
      a_valid[k] = 1; b_valid[k] = 1; rsp_ready[k] = 1;
      @(negedge clk); #1;
      checks++;
      if ({a_ready[k], b_ready[k], rsp_valid[k]} !== 3'b000) begin
        errors++; $display("FAIL reset_ctl k=%0d got=%b exp=000", k, {a_ready[k], b_ready[k], rsp_valid[k]});
      end
      checks++;
      if ({rsp_data[k], rsp_id[k], mult_m[k], mult_q[k]} !== 17'h0) begin
        errors++; $display("FAIL reset_regs k=%0d data=%h id=%b m=%h q=%h exp=0", k, rsp_data[k], rsp_id[k], mult_m[k], mult_q[k]);
      end
      rst[k] = 0;
      clear_inputs(k);
    end
  endtask

  task automatic test_latency(input int k, input logic [3:0] m, input logic [3:0] q);
    int n = 0;
    logic [7:0] exp_p = {4'b0, m} * {4'b0, q};
    do_reset(k);
    a_valid[k] = 1; a_m[k] = m; a_q[k] = q; rsp_ready[k] = 1;
    #1;
    checks++;
    if (a_ready[k] !== 1'b1) begin errors++; $display("FAIL lat_accept k=%0d got=%b exp=1", k, a_ready[k]); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      a_valid[k] = 0;
      n++;
      #1;
      if (n == 1) begin
        checks++;
        if ({mult_m[k], mult_q[k]} !== {m, q}) begin
          errors++; $display("FAIL lat_operands k=%0d got=%h exp=%h", k, {mult_m[k], mult_q[k]}, {m, q});
        end
      end
      if (rsp_valid[k]) break;
    end
    checks++;
    if (n != settle(k) + 1) begin errors++; $display("FAIL lat_cycles k=%0d got=%0d exp=%0d", k, n, settle(k) + 1); end
    checks++;
    if ({rsp_data[k], rsp_id[k]} !== {exp_p, 1'b0}) begin
      errors++; $display("FAIL lat_data k=%0d got=%h/%b exp=%h/0", k, rsp_data[k], rsp_id[k], exp_p);
    end
    @(negedge clk);
    clear_inputs(k);
  endtask

  task automatic test_contention();
    bit seen = 0;
    do_reset(0);
    a_valid[0] = 1; a_m[0] = 3;  a_q[0] = 4;
    b_valid[0] = 1; b_m[0] = 15; b_q[0] = 15;
    rsp_ready[0] = 1;
    #1;
    checks++;
    if ({a_ready[0], b_ready[0]} !== 2'b10) begin
      errors++; $display("FAIL cont_grant got=%b exp=10", {a_ready[0], b_ready[0]});
    end
    @(negedge clk);
    a_valid[0] = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (b_ready[0] !== 1'b0) begin errors++; $display("FAIL cont_b_wait cyc=%0d got=%b exp=0", i, b_ready[0]); end
      if (rsp_valid[0]) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen || {rsp_data[0], rsp_id[0]} !== {8'h0C, 1'b0}) begin
      errors++; $display("FAIL cont_rsp_a seen=%b got=%h/%b exp=0c/0", seen, rsp_data[0], rsp_id[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (b_ready[0] !== 1'b1) begin errors++; $display("FAIL cont_b_grant got=%b exp=1", b_ready[0]); end
    seen = 0;
    @(negedge clk);
    b_valid[0] = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rsp_valid[0]) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen || {rsp_data[0], rsp_id[0]} !== {8'hE1, 1'b1}) begin
      errors++; $display("FAIL cont_rsp_b seen=%b got=%h/%b exp=e1/1", seen, rsp_data[0], rsp_id[0]);
    end
    @(negedge clk);
    clear_inputs(0);
  endtask

  task automatic test_stall(input int k);
    bit seen = 0;
    do_reset(k);
    a_valid[k] = 1; a_m[k] = 2; a_q[k] = 6;
    b_valid[k] = 1; b_m[k] = 9; b_q[k] = 9;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (rsp_valid[k]) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_timeout k=%0d got=no response exp=response", k); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid[k], rsp_data[k], rsp_id[k], a_ready[k], b_ready[k]} !== {1'b1, 8'd12, 3'b000}) begin
        errors++;
        $display("FAIL stall_hold k=%0d cyc=%0d got v=%b d=%h id=%b ar=%b br=%b exp v=1 d=0c id=0 ar=0 br=0",
                 k, i, rsp_valid[k], rsp_data[k], rsp_id[k], a_ready[k], b_ready[k]);
      end
      @(negedge clk); #1;
    end
    clear_inputs(k);
  endtask

  task automatic test_reset_mid_compute();
    logic [7:0] d; logic id; bit ok;
    do_reset(1);
    a_valid[1] = 1; a_m[1] = 5; a_q[1] = 5; rsp_ready[1] = 1;
    @(negedge clk);           // COMPUTE cycle 1
    a_valid[1] = 0;
    @(negedge clk);           // COMPUTE cycle 2
    rst[1] = 1;
    @(negedge clk);
    rst[1] = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp cyc=%0d got=%b exp=0", i, rsp_valid[1]); end
      @(negedge clk);
    end
    rsp_ready[1] = 0;
    run_txn(1, 1'b1, 4'd9, 4'd11, d, id, ok);
    checks++;
    if (!ok || {d, id} !== {8'd99, 1'b1}) begin
      errors++; $display("FAIL rstmid_next ok=%b got=%h/%b exp=63/1", ok, d, id);
    end
  endtask

  // Reference model works in terms of transactions and response timestamps.
  task automatic test_random(input int k, input int n);
    int mode = 0;              // 0 free, 1 awaiting response, 2 response offered
    bit ptr_b = 0;
    int resp_cyc = 0;
    logic [7:0] exp_d = '0;
    bit exp_id = 0;
    bit ga, gb;
    do_reset(k);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      a_valid[k] = 1'($urandom_range(0, 1)); b_valid[k] = 1'($urandom_range(0, 1));
      a_m[k] = 4'($urandom_range(0, 15)); a_q[k] = 4'($urandom_range(0, 15));
      b_m[k] = 4'($urandom_range(0, 15)); b_q[k] = 4'($urandom_range(0, 15));
      rsp_ready[k] = ($urandom_range(0, 2) != 0);
      #1;
      ga = 0; gb = 0;
      if (mode == 0) begin
        if (a_valid[k] && b_valid[k]) begin ga = !ptr_b; gb = ptr_b; end
        else begin ga = a_valid[k]; gb = b_valid[k]; end
      end
      checks++;
      if ({a_ready[k], b_ready[k]} !== {ga, gb}) begin
        errors++; $display("FAIL rand_ready k=%0d cyc=%0d got=%b%b exp=%b%b", k, c, a_ready[k], b_ready[k], ga, gb);
      end
      checks++;
      if (rsp_valid[k] !== (mode == 2)) begin
        errors++; $display("FAIL rand_valid k=%0d cyc=%0d got=%b exp=%b", k, c, rsp_valid[k], mode == 2);
      end
      if (mode == 2) begin
        checks++;
        if ({rsp_data[k], rsp_id[k]} !== {exp_d, exp_id}) begin
          errors++; $display("FAIL rand_data k=%0d cyc=%0d got=%h/%b exp=%h/%b", k, c, rsp_data[k], rsp_id[k], exp_d, exp_id);
        end
      end
      if (ga || gb) begin
        exp_id = gb;
        exp_d = gb ? {4'b0, b_m[k]} * {4'b0, b_q[k]} : {4'b0, a_m[k]} * {4'b0, a_q[k]};
        ptr_b = ga;
        resp_cyc = c + settle(k) + 1;
        mode = 1;
      end else if (mode == 1 && c + 1 == resp_cyc) mode = 2;
      else if (mode == 2 && rsp_ready[k]) mode = 0;
    end
    @(negedge clk);
    clear_inputs(k);
  endtask

`ifdef MULT_ARB_ACC_EN
  task automatic test_acc();
    logic [7:0] d; logic id; bit ok;
    int exp_acc;
    do_reset(0);
    #1;
    checks++;
    if (acc_out[0] !== 12'd0) begin errors++; $display("FAIL acc_reset got=%0d exp=0", acc_out[0]); end
    run_txn(0, 1'b0, 4'd3, 4'd5, d, id, ok);
    run_txn(0, 1'b1, 4'd15, 4'd15, d, id, ok);
    #1;
    checks++;
    if (acc_out[0] !== 12'd240) begin errors++; $display("FAIL acc_sum got=%0d exp=240", acc_out[0]); end
    exp_acc = 240;
    for (int i = 0; i < 20; i++) begin
      run_txn(0, 1'b0, 4'd15, 4'd15, d, id, ok);
      exp_acc = (exp_acc + 225) % 4096;
    end
    #1;
    checks++;
    if (acc_out[0] !== 12'(exp_acc)) begin errors++; $display("FAIL acc_wrap got=%0d exp=%0d", acc_out[0], exp_acc); end
    @(negedge clk); acc_clr[0] = 1;
    @(negedge clk); acc_clr[0] = 0; #1;
    checks++;
    if (acc_out[0] !== 12'd0) begin errors++; $display("FAIL acc_clear got=%0d exp=0", acc_out[0]); end
    run_txn(0, 1'b0, 4'd4, 4'd4, d, id, ok);
    @(negedge clk);
    a_valid[0] = 1; a_m[0] = 2; a_q[0] = 3; rsp_ready[0] = 1;
    @(negedge clk);           // COMPUTE: capture this cycle
    a_valid[0] = 0; acc_clr[0] = 1;
    @(negedge clk);
    acc_clr[0] = 0; #1;
    checks++;
    if (acc_out[0] !== 12'd6) begin errors++; $display("FAIL acc_clr_load got=%0d exp=6", acc_out[0]); end
    @(negedge clk);
    clear_inputs(0);
  endtask
`endif

  initial begin
    for (int k = 0; k < 2; k++) begin rst[k] = 1; clear_inputs(k); end
    repeat (2) @(negedge clk);
    rst[0] = 0; rst[1] = 0;
    test_reset();
    test_latency(0, 4'd7, 4'd9);
    test_latency(1, 4'd13, 4'd6);
    test_contention();
    test_stall(0);
    test_stall(1);
    test_reset_mid_compute();
    test_random(0, 400);
    test_random(1, 400);
`ifdef MULT_ARB_ACC_EN
    test_acc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
